tinyqv_fetch_sequencer: RTL and testbench



---
 rtl/tinyqv_fetch_sequencer.sv | 118 +++++++++++
 tb/tb_tinyqv_fetch_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_fetch_sequencer.sv
// rtl/tinyqv_fetch_sequencer.sv - instruction fetch sequencer: restart, start delay, halfword streaming
module tinyqv_fetch_sequencer #(
    parameter int START_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:0] instr_addr,
    input  logic        instr_fetch_restart,
    input  logic        instr_fetch_stall,
    output logic        instr_fetch_started,
    output logic        instr_fetch_stopped,
    output logic [15:0] instr_data_in,
    output logic        instr_ready,
    output logic [22:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    localparam logic [3:0] START_LOAD = 4'(START_CYCLES);

    state_t      state;
    logic [3:0]  counter;
    logic [22:0] fetch_addr;
    logic [15:0] buf_data;
    logic        buf_valid;
    logic        ack_seen;

    // An ack only counts while a request is actually outstanding.
    assign ack_seen = mem_req & mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            counter             <= 4'd0;
            fetch_addr          <= 23'd0;
            buf_data            <= 16'd0;
            buf_valid           <= 1'b0;
            instr_fetch_started <= 1'b0;
            instr_fetch_stopped <= 1'b0;
            instr_data_in       <= 16'd0;
            instr_ready         <= 1'b0;
            mem_addr            <= 23'd0;
            mem_req             <= 1'b0;
        end else begin
            instr_fetch_started <= 1'b0;
            instr_fetch_stopped <= 1'b0;
            instr_ready         <= 1'b0;

            case (state)
                IDLE: begin
                    if (instr_fetch_restart) begin
                        fetch_addr <= instr_addr;
                        counter    <= START_LOAD;
                        state      <= START;
                    end
                end

                START: begin
                    if (instr_fetch_restart) begin
                        fetch_addr <= instr_addr;
                        counter    <= START_LOAD;
                    end else if (counter == 4'd1) begin
                        instr_fetch_started <= 1'b1;
                        state               <= STREAM;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end

                STREAM: begin
                    if (ack_seen) begin
                        mem_req <= 1'b0;
                    end
                    if (instr_fetch_restart) begin
                        // Any buffered or in-flight halfword belongs to the old stream.
                        fetch_addr <= instr_addr;
                        buf_valid  <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        if (ack_seen) begin
                            buf_data   <= mem_rdata;
                            buf_valid  <= 1'b1;
                            fetch_addr <= fetch_addr + 23'd1;
                        end else if (!mem_req && !buf_valid && !instr_fetch_stall) begin
                            mem_req  <= 1'b1;
                            mem_addr <= fetch_addr;
                        end
                        // A request is only issued with the buffer empty, so an ack
                        // never coincides with a delivery here.
                        if (buf_valid && !instr_fetch_stall) begin
                            instr_ready   <= 1'b1;
                            instr_data_in <= buf_data;
                            buf_valid     <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    if (instr_fetch_restart) begin
                        fetch_addr <= instr_addr;
                    end
                    if (!mem_req || mem_ack) begin
                        mem_req             <= 1'b0;
                        instr_fetch_stopped <= 1'b1;
                        counter             <= START_LOAD;
                        state               <= START;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyqv_fetch_sequencer.sv
// tb/tb_tinyqv_fetch_sequencer.sv - randomized self-checking bench for tinyqv_fetch_sequencer
module tb_tinyqv_fetch_sequencer;

    localparam int START_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] instr_addr;
    logic        instr_fetch_restart;
    logic        instr_fetch_stall;
    logic        instr_fetch_started;
    logic        instr_fetch_stopped;
    logic [15:0] instr_data_in;
    logic        instr_ready;
    logic [22:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int mem_lat = 1;
    int viol = 0;

    int          started_q[$];
    int          stopped_q[$];
    int          rdy_cyc_q[$];
    logic [15:0] rdy_data_q[$];
    int          ack_cyc_q[$];
    logic [22:0] ack_addr_q[$];
    int          req_cyc_q[$];

    tinyqv_fetch_sequencer #(.START_CYCLES(START_CYCLES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data_in       (instr_data_in),
        .instr_ready         (instr_ready),
        .mem_addr            (mem_addr),
        .mem_req             (mem_req),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [22:0] a);
        return 16'hA000 + a[15:0];
    endfunction

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: acks mem_lat cycles after the request appears, checks address stability.
    initial begin : responder
        int cnt;
        logic [22:0] held;
        cnt = 0; held = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                cnt = 0;
            end else begin
                if (cnt == 0) held = mem_addr;
                else if (mem_addr !== held) viol++;
                if (cnt >= mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data(mem_addr);
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Logs output events by cycle; cycle X is the period after clock edge X.
    initial begin : monitor
        logic prev_req, prev_stall;
        prev_req = 1'b0; prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_fetch_started) started_q.push_back(cyc);
            if (instr_fetch_stopped) stopped_q.push_back(cyc);
            if (instr_ready) begin
                rdy_cyc_q.push_back(cyc);
                rdy_data_q.push_back(instr_data_in);
            end
            if (mem_req && !prev_req) req_cyc_q.push_back(cyc);
            if (mem_req && mem_ack) begin
                ack_cyc_q.push_back(cyc + 1);
                ack_addr_q.push_back(mem_addr);
            end
            if (instr_fetch_started && instr_fetch_stopped) viol++;
            if (instr_ready && (instr_fetch_started || instr_fetch_stopped || prev_stall)) viol++;
            prev_req   = mem_req;
            prev_stall = instr_fetch_stall;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_logs();
        started_q.delete(); stopped_q.delete();
        rdy_cyc_q.delete(); rdy_data_q.delete();
        ack_cyc_q.delete(); ack_addr_q.delete(); req_cyc_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        instr_fetch_restart = 1'b0;
        instr_fetch_stall = 1'b0;
        step(2);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic do_restart(input logic [22:0] a, output int e);
        instr_addr = a;
        instr_fetch_restart = 1'b1;
        @(posedge clk); #1;
        instr_fetch_restart = 1'b0;
        e = cyc;
    endtask

    task automatic wait_ready(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rdy_data_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (rdy_data_q.size() < n)
            $display("FAIL %s_timeout: readies=%0d required=%0d", tag, rdy_data_q.size(), n);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_addr = '0; instr_fetch_restart = 1'b0; instr_fetch_stall = 1'b0;
        @(posedge clk); #1;
        checks++; if (instr_fetch_started !== 1'b0) $display("FAIL reset_started: got %b want 0", instr_fetch_started); else passes++;
        checks++; if (instr_fetch_stopped !== 1'b0) $display("FAIL reset_stopped: got %b want 0", instr_fetch_stopped); else passes++;
        checks++; if (instr_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", instr_ready); else passes++;
        checks++; if (instr_data_in !== 16'h0) $display("FAIL reset_data: got %h want 0", instr_data_in); else passes++;
        checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else passes++;
        checks++; if (mem_addr !== 23'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passes++;
        rst = 1'b0;
        clear_logs();
        step(10);
        checks++; if (started_q.size() != 0) $display("FAIL idle_started: got %0d pulses want 0", started_q.size()); else passes++;
        checks++; if (req_cyc_q.size() != 0) $display("FAIL idle_req: got %0d requests want 0", req_cyc_q.size()); else passes++;
    endtask

    task automatic test_basic();
        int e;
        apply_reset();
        mem_lat = 1;
        do_restart(23'h000100, e);
        wait_ready(3, 80, "basic");
        checks++; if (started_q[0] !== e + START_CYCLES) $display("FAIL basic_started_cycle: got %0d want %0d", started_q[0], e + START_CYCLES); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rdy_data_q[i] !== mem_data(23'h100 + 23'(i))) $display("FAIL basic_data%0d: got %h want %h", i, rdy_data_q[i], mem_data(23'h100 + 23'(i))); else passes++;
            checks++; if (ack_addr_q[i] !== 23'h100 + 23'(i)) $display("FAIL basic_addr%0d: got %h want %h", i, ack_addr_q[i], 23'h100 + 23'(i)); else passes++;
            checks++; if (rdy_cyc_q[i] !== ack_cyc_q[i] + 1) $display("FAIL basic_latency%0d: ready at %0d want %0d", i, rdy_cyc_q[i], ack_cyc_q[i] + 1); else passes++;
        end
        checks++; if (stopped_q.size() != 0) $display("FAIL basic_stopped: got %0d pulses want 0", stopped_q.size()); else passes++;
    endtask

    task automatic test_stall();
        int e, k, r, n_rdy, n_req, n_ack, first_after;
        apply_reset();
        mem_lat = 2;
        do_restart(23'h000200, e);
        wait_ready(2, 80, "stall_pre");
        k = 0;
        while (!mem_req && k < 20) begin step(1); k++; end
        r = cyc;
        instr_fetch_stall = 1'b1;
        step(6);
        instr_fetch_stall = 1'b0;
        wait_ready(6, 120, "stall_post");
        n_rdy = 0; n_req = 0; n_ack = 0; first_after = -1;
        foreach (rdy_cyc_q[j]) begin
            if (rdy_cyc_q[j] > r && rdy_cyc_q[j] <= r + 6) n_rdy++;
            if (rdy_cyc_q[j] > r && first_after < 0) first_after = rdy_cyc_q[j];
        end
        foreach (req_cyc_q[j]) if (req_cyc_q[j] > r && req_cyc_q[j] <= r + 6) n_req++;
        foreach (ack_cyc_q[j]) if (ack_cyc_q[j] > r && ack_cyc_q[j] <= r + 6) n_ack++;
        checks++; if (n_rdy != 0) $display("FAIL stall_no_ready: got %0d readies want 0", n_rdy); else passes++;
        checks++; if (n_req != 0) $display("FAIL stall_no_req: got %0d requests want 0", n_req); else passes++;
        checks++; if (n_ack != 1) $display("FAIL stall_ack_inside: got %0d acks want 1", n_ack); else passes++;
        checks++; if (first_after != r + 7) $display("FAIL stall_release: ready at %0d want %0d", first_after, r + 7); else passes++;
        for (int i = 0; i < 6; i++) begin
            checks++; if (rdy_data_q[i] !== mem_data(23'h200 + 23'(i))) $display("FAIL stall_data%0d: got %h want %h", i, rdy_data_q[i], mem_data(23'h200 + 23'(i))); else passes++;
        end
    endtask

    task automatic test_drain();
        int e, k, r;
        apply_reset();
        mem_lat = 3;
        do_restart(23'h000100, e);
        k = 0;
        while (!(mem_req && mem_addr == 23'h105) && k < 200) begin step(1); k++; end
        checks++; if (!(mem_req && mem_addr == 23'h105)) $display("FAIL drain_find_req: addr %h req %b want 105 1", mem_addr, mem_req); else passes++;
        r = cyc;
        do_restart(23'h000040, e);
        wait_ready(8, 150, "drain");
        checks++; if (stopped_q.size() != 1) $display("FAIL drain_stopped_count: got %0d want 1", stopped_q.size()); else passes++;
        checks++; if (stopped_q[0] !== r + 4) $display("FAIL drain_stopped_cycle: got %0d want %0d", stopped_q[0], r + 4); else passes++;
        checks++; if (started_q[1] !== r + 4 + START_CYCLES) $display("FAIL drain_started_cycle: got %0d want %0d", started_q[1], r + 4 + START_CYCLES); else passes++;
        checks++; if (ack_addr_q[6] !== 23'h40) $display("FAIL drain_next_addr: got %h want 40", ack_addr_q[6]); else passes++;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] want;
            want = (i < 5) ? mem_data(23'h100 + 23'(i)) : mem_data(23'h40 + 23'(i - 5));
            checks++; if (rdy_data_q[i] !== want) $display("FAIL drain_data%0d: got %h want %h", i, rdy_data_q[i], want); else passes++;
        end
    endtask

    task automatic test_wrap();
        int e;
        logic [22:0] ea;
        apply_reset();
        mem_lat = $urandom_range(0, 3);
        do_restart(23'h7FFFFE, e);
        wait_ready(4, 120, "wrap");
        for (int i = 0; i < 4; i++) begin
            ea = 23'h7FFFFE + 23'(i);
            checks++; if (ack_addr_q[i] !== ea) $display("FAIL wrap_addr%0d: got %h want %h", i, ack_addr_q[i], ea); else passes++;
            checks++; if (rdy_data_q[i] !== mem_data(ea)) $display("FAIL wrap_data%0d: got %h want %h", i, rdy_data_q[i], mem_data(ea)); else passes++;
        end
    endtask

    task automatic test_start_restart();
        int e1, e2;
        apply_reset();
        mem_lat = 1;
        do_restart(23'h000300, e1);
        step(1);
        do_restart(23'h000310, e2);
        wait_ready(2, 80, "start_restart");
        checks++; if (started_q.size() != 1) $display("FAIL start_restart_count: got %0d want 1", started_q.size()); else passes++;
        checks++; if (started_q[0] !== e2 + START_CYCLES) $display("FAIL start_restart_cycle: got %0d want %0d", started_q[0], e2 + START_CYCLES); else passes++;
        checks++; if (stopped_q.size() != 0) $display("FAIL start_restart_stopped: got %0d want 0", stopped_q.size()); else passes++;
        checks++; if (ack_addr_q[0] !== 23'h310) $display("FAIL start_restart_addr: got %h want 310", ack_addr_q[0]); else passes++;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rdy_data_q[i] !== mem_data(23'h310 + 23'(i))) $display("FAIL start_restart_data%0d: got %h want %h", i, rdy_data_q[i], mem_data(23'h310 + 23'(i))); else passes++;
        end
    endtask

    task automatic test_ack_restart();
        int e, k, kk, nold;
        logic [22:0] x;
        apply_reset();
        mem_lat = 2;
        do_restart(23'h000280, e);
        wait_ready(2, 80, "ack_restart_pre");
        kk = 0;
        do begin
            @(posedge clk); #2;
            kk++;
        end while (!mem_ack && kk < 40);
        x = mem_addr;
        instr_addr = 23'h000500;
        instr_fetch_restart = 1'b1;
        @(posedge clk); #1;
        instr_fetch_restart = 1'b0;
        k = cyc;
        nold = int'(x - 23'h280);
        wait_ready(nold + 2, 100, "ack_restart_post");
        checks++; if (stopped_q[0] !== k + 1) $display("FAIL ack_restart_stopped: got %0d want %0d", stopped_q[0], k + 1); else passes++;
        checks++; if (started_q[1] !== k + 1 + START_CYCLES) $display("FAIL ack_restart_started: got %0d want %0d", started_q[1], k + 1 + START_CYCLES); else passes++;
        for (int i = 0; i < nold + 2; i++) begin
            logic [15:0] want;
            want = (i < nold) ? mem_data(23'h280 + 23'(i)) : mem_data(23'h500 + 23'(i - nold));
            checks++; if (rdy_data_q[i] !== want) $display("FAIL ack_restart_data%0d: got %h want %h", i, rdy_data_q[i], want); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int e, k;
        apply_reset();
        mem_lat = 3;
        do_restart(23'h000600, e);
        k = 0;
        while (!mem_req && k < 40) begin step(1); k++; end
        checks++; if (mem_req !== 1'b1) $display("FAIL rstmid_req_before: got %b want 1", mem_req); else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req: got %b want 0", mem_req); else passes++;
        checks++; if (mem_addr !== 23'h0) $display("FAIL rstmid_addr: got %h want 0", mem_addr); else passes++;
        checks++; if ({instr_fetch_started, instr_fetch_stopped, instr_ready} !== 3'b000) $display("FAIL rstmid_pulses: got %b want 000", {instr_fetch_started, instr_fetch_stopped, instr_ready}); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        step(12);
        checks++; if (started_q.size() + req_cyc_q.size() + rdy_data_q.size() != 0) $display("FAIL rstmid_idle: got %0d events want 0", started_q.size() + req_cyc_q.size() + rdy_data_q.size()); else passes++;
        do_restart(23'h000610, e);
        wait_ready(1, 60, "rstmid_resume");
        checks++; if (started_q[0] !== e + START_CYCLES) $display("FAIL rstmid_started: got %0d want %0d", started_q[0], e + START_CYCLES); else passes++;
        checks++; if (rdy_data_q[0] !== mem_data(23'h610)) $display("FAIL rstmid_data: got %h want %h", rdy_data_q[0], mem_data(23'h610)); else passes++;
    endtask

    task automatic test_random();
        int e;
        logic [22:0] a;
        logic [15:0] got[$];
        apply_reset();
        for (int it = 0; it < 5; it++) begin
            mem_lat = $urandom_range(0, 3);
            a = (it == 2) ? 23'h7FFFFD : 23'($urandom);
            clear_logs();
            do_restart(a, e);
            for (int c = 0; c < 30; c++) begin
                instr_fetch_stall = 1'($urandom_range(0, 1));
                step(1);
            end
            instr_fetch_stall = 1'b0;
            step(25);
            got.delete();
            foreach (rdy_cyc_q[j]) if (rdy_cyc_q[j] > e) got.push_back(rdy_data_q[j]);
            checks++; if (got.size() < 3) $display("FAIL random%0d_progress: got %0d readies want >=3", it, got.size()); else passes++;
            foreach (got[i]) begin
                checks++; if (got[i] !== mem_data(a + 23'(i))) $display("FAIL random%0d_data%0d: got %h want %h", it, i, got[i], mem_data(a + 23'(i))); else passes++;
            end
        end
    endtask

    task automatic test_invariants();
        checks++; if (viol != 0) $display("FAIL invariants: got %0d violations want 0", viol); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drain();
        test_wrap();
        test_start_restart();
        test_ack_restart();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
